// File: rtl/controlador_juego.sv
// Tic-tac-toe game controller: detects moves from the cell selector codes,
// keeps the authoritative board, enforces turn timeouts and reports the result.
module controlador_juego #(
    parameter int TIEMPO_TURNO = 50000000,
    parameter int ANCHO_CONT   = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        boton_reinicio,
    input  logic [1:0]  guarda_c1,
    input  logic [1:0]  guarda_c2,
    input  logic [1:0]  guarda_c3,
    input  logic [1:0]  guarda_c4,
    input  logic [1:0]  guarda_c5,
    input  logic [1:0]  guarda_c6,
    input  logic [1:0]  guarda_c7,
    input  logic [1:0]  guarda_c8,
    input  logic [1:0]  guarda_c9,
    output logic        turno_p1,
    output logic        turno_p2,
    output logic [17:0] tablero,
    output logic        gana_p1,
    output logic        gana_p2,
    output logic        empate,
    output logic [7:0]  linea_ganadora,
    output logic        jugada_invalida,
    output logic        tiempo_agotado,
    output logic [2:0]  estado_o
);

    typedef enum logic [2:0] {
        INICIO   = 3'd0,
        TURNO_P1 = 3'd1,
        EVAL_P1  = 3'd2,
        TURNO_P2 = 3'd3,
        EVAL_P2  = 3'd4,
        FIN      = 3'd5
    } estado_t;

    estado_t               estado_q;
    logic [17:0]           tablero_q;
    logic [17:0]           prev_q;
    logic [ANCHO_CONT-1:0] timer_q;
    logic                  turno_p1_q, turno_p2_q;
    logic                  gana_p1_q, gana_p2_q, empate_q;
    logic [7:0]            linea_q;
    logic                  invalida_q, agotado_q;

    logic [17:0] guarda_v;
    logic        cambio;
    logic [3:0]  idx;
    logic [1:0]  codigo_cambio;
    logic [1:0]  codigo_turno;
    logic [1:0]  codigo_eval;
    logic        en_turno;
    logic        es_jugada;
    logic        valida;
    logic        fin_tiempo;
    logic        lleno;
    logic [7:0]  lineas;

    function automatic logic [7:0] lineas_de(input logic [17:0] t, input logic [1:0] c);
        logic [8:0] m;
        for (int k = 0; k < 9; k++) m[k] = (t[2*k +: 2] == c);
        return {m[2] & m[4] & m[6], m[0] & m[4] & m[8],
                m[2] & m[5] & m[8], m[1] & m[4] & m[7], m[0] & m[3] & m[6],
                m[6] & m[7] & m[8], m[3] & m[4] & m[5], m[0] & m[1] & m[2]};
    endfunction

    assign guarda_v = {guarda_c9, guarda_c8, guarda_c7, guarda_c6, guarda_c5,
                       guarda_c4, guarda_c3, guarda_c2, guarda_c1};

    // Descending scan so the lowest-index changed cell is the one kept.
    always_comb begin
        cambio = 1'b0;
        idx    = 4'd0;
        for (int k = 8; k >= 0; k--) begin
            if (guarda_v[2*k +: 2] != prev_q[2*k +: 2]) begin
                cambio = 1'b1;
                idx    = 4'(k);
            end
        end
    end

    assign codigo_cambio = guarda_v[{idx, 1'b0} +: 2];
    assign en_turno      = (estado_q == TURNO_P1) || (estado_q == TURNO_P2);
    assign codigo_turno  = (estado_q == TURNO_P1) ? 2'b11 : 2'b01;
    assign codigo_eval   = (estado_q == EVAL_P1) ? 2'b11 : 2'b01;
    assign es_jugada     = en_turno && cambio && (codigo_cambio == codigo_turno);
    assign valida        = es_jugada && (tablero_q[{idx, 1'b0} +: 2] == 2'b00);
    assign fin_tiempo    = (timer_q == ANCHO_CONT'(TIEMPO_TURNO - 1));
    assign lineas        = lineas_de(tablero_q, codigo_eval);

    always_comb begin
        lleno = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (tablero_q[2*k +: 2] == 2'b00) lleno = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q   <= INICIO;
            tablero_q  <= '0;
            prev_q     <= '0;
            timer_q    <= '0;
            turno_p1_q <= 1'b0;
            turno_p2_q <= 1'b0;
            gana_p1_q  <= 1'b0;
            gana_p2_q  <= 1'b0;
            empate_q   <= 1'b0;
            linea_q    <= '0;
            invalida_q <= 1'b0;
            agotado_q  <= 1'b0;
        end else begin
            prev_q     <= guarda_v;
            invalida_q <= 1'b0;
            agotado_q  <= 1'b0;
            if (boton_reinicio) begin
                estado_q   <= INICIO;
                turno_p1_q <= 1'b0;
                turno_p2_q <= 1'b0;
            end else begin
                case (estado_q)
                    INICIO: begin
                        tablero_q  <= '0;
                        timer_q    <= '0;
                        gana_p1_q  <= 1'b0;
                        gana_p2_q  <= 1'b0;
                        empate_q   <= 1'b0;
                        linea_q    <= '0;
                        estado_q   <= TURNO_P1;
                        turno_p1_q <= 1'b1;
                    end
                    TURNO_P1, TURNO_P2: begin
                        if (valida) begin
                            tablero_q[{idx, 1'b0} +: 2] <= codigo_turno;
                            estado_q   <= (estado_q == TURNO_P1) ? EVAL_P1 : EVAL_P2;
                            turno_p1_q <= 1'b0;
                            turno_p2_q <= 1'b0;
                        end else begin
                            invalida_q <= es_jugada;
                            if (fin_tiempo) begin
                                agotado_q  <= 1'b1;
                                timer_q    <= '0;
                                estado_q   <= (estado_q == TURNO_P1) ? TURNO_P2 : TURNO_P1;
                                turno_p1_q <= (estado_q == TURNO_P2);
                                turno_p2_q <= (estado_q == TURNO_P1);
                            end else begin
                                timer_q <= timer_q + 1'b1;
                            end
                        end
                    end
                    EVAL_P1, EVAL_P2: begin
                        if (|lineas) begin
                            gana_p1_q <= (estado_q == EVAL_P1);
                            gana_p2_q <= (estado_q == EVAL_P2);
                            linea_q   <= lineas;
                            estado_q  <= FIN;
                        end else if (lleno) begin
                            empate_q <= 1'b1;
                            estado_q <= FIN;
                        end else begin
                            timer_q    <= '0;
                            estado_q   <= (estado_q == EVAL_P1) ? TURNO_P2 : TURNO_P1;
                            turno_p1_q <= (estado_q == EVAL_P2);
                            turno_p2_q <= (estado_q == EVAL_P1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign turno_p1        = turno_p1_q;
    assign turno_p2        = turno_p2_q;
    assign tablero         = tablero_q;
    assign gana_p1         = gana_p1_q;
    assign gana_p2         = gana_p2_q;
    assign empate          = empate_q;
    assign linea_ganadora  = linea_q;
    assign jugada_invalida = invalida_q;
    assign tiempo_agotado  = agotado_q;
    assign estado_o        = estado_q;

endmodule

// File: tb/tb_controlador_juego.sv
// Directed bench for controlador_juego with a short turn time so the timeout path is reachable.
module tb_controlador_juego;

    logic        clk;
    logic        rst_n;
    logic        boton_reinicio;
    logic [1:0]  g [1:9];
    logic        turno_p1, turno_p2;
    logic [17:0] tablero;
    logic        gana_p1, gana_p2, empate;
    logic [7:0]  linea_ganadora;
    logic        jugada_invalida, tiempo_agotado;
    logic [2:0]  estado_o;

    int checks   = 0;
    int failures = 0;

    controlador_juego #(.TIEMPO_TURNO(8), .ANCHO_CONT(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .boton_reinicio  (boton_reinicio),
        .guarda_c1       (g[1]),
        .guarda_c2       (g[2]),
        .guarda_c3       (g[3]),
        .guarda_c4       (g[4]),
        .guarda_c5       (g[5]),
        .guarda_c6       (g[6]),
        .guarda_c7       (g[7]),
        .guarda_c8       (g[8]),
        .guarda_c9       (g[9]),
        .turno_p1        (turno_p1),
        .turno_p2        (turno_p2),
        .tablero         (tablero),
        .gana_p1         (gana_p1),
        .gana_p2         (gana_p2),
        .empate          (empate),
        .linea_ganadora  (linea_ganadora),
        .jugada_invalida (jugada_invalida),
        .tiempo_agotado  (tiempo_agotado),
        .estado_o        (estado_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic play(input int k, input logic [1:0] code);
        g[k] = code;
        tick();
        tick();
    endtask

    task automatic clear_g();
        for (int k = 1; k <= 9; k++) g[k] = 2'b00;
    endtask

    task automatic new_game();
        boton_reinicio = 1'b1;
        tick();
        boton_reinicio = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        boton_reinicio = 1'b0;
        clear_g();
        g[1] = 2'b11;
        tick();
        tick();
        check_eq("rst_tablero", 32'(tablero), 32'h0);
        check_eq("rst_turnos", {30'd0, turno_p1, turno_p2}, 32'h0);
        check_eq("rst_estado", 32'(estado_o), 32'd0);
        check_eq("rst_results", {29'd0, gana_p1, gana_p2, empate}, 32'h0);
        check_eq("rst_pulses", {30'd0, jugada_invalida, tiempo_agotado}, 32'h0);

        rst_n = 1'b1;
        tick();
        check_eq("inicio_to_p1", {30'd0, turno_p1, turno_p2}, 32'h2);
        tick();
        check_eq("stale_no_move", 32'(tablero), 32'h0);

        g[5] = 2'b11;
        tick();
        check_eq("c5_written", 32'(tablero), 32'h300);
        check_eq("eval_turnos", {30'd0, turno_p1, turno_p2}, 32'h0);
        tick();
        check_eq("turn_to_p2", {30'd0, turno_p1, turno_p2}, 32'h1);

        g[5] = 2'b01;
        tick();
        check_eq("invalid_pulse", 32'(jugada_invalida), 32'h1);
        check_eq("invalid_tablero", 32'(tablero), 32'h300);
        check_eq("invalid_stay_p2", {30'd0, turno_p1, turno_p2}, 32'h1);
        tick();
        check_eq("invalid_one_cycle", 32'(jugada_invalida), 32'h0);

        clear_g();
        new_game();
        check_eq("ng_tablero", 32'(tablero), 32'h0);
        check_eq("ng_turno", {30'd0, turno_p1, turno_p2}, 32'h2);

        play(1, 2'b11);
        play(4, 2'b01);
        play(2, 2'b11);
        play(5, 2'b01);
        g[3] = 2'b11;
        tick();
        check_eq("row_board", 32'(tablero), 32'h17F);
        check_eq("row_not_yet", 32'(gana_p1), 32'h0);
        tick();
        check_eq("row_gana_p1", 32'(gana_p1), 32'h1);
        check_eq("row_linea", 32'(linea_ganadora), 32'h01);
        check_eq("row_others", {30'd0, gana_p2, empate}, 32'h0);
        check_eq("row_turnos", {30'd0, turno_p1, turno_p2}, 32'h0);
        g[6] = 2'b11;
        tick();
        check_eq("fin_hold_board", 32'(tablero), 32'h17F);
        check_eq("fin_hold_gana", 32'(gana_p1), 32'h1);
        check_eq("fin_state", 32'(estado_o), 32'd5);

        boton_reinicio = 1'b1;
        tick();
        check_eq("restart_inicio", 32'(estado_o), 32'd0);
        boton_reinicio = 1'b0;
        tick();
        check_eq("restart_tablero", 32'(tablero), 32'h0);
        check_eq("restart_gana", 32'(gana_p1), 32'h0);
        check_eq("restart_linea", 32'(linea_ganadora), 32'h0);
        check_eq("restart_turno", {30'd0, turno_p1, turno_p2}, 32'h2);
        tick();
        check_eq("restart_stale", 32'(tablero), 32'h0);

        new_game();
        repeat (7) tick();
        check_eq("to_not_yet", {30'd0, tiempo_agotado, turno_p1}, 32'h1);
        tick();
        check_eq("to_pulse", 32'(tiempo_agotado), 32'h1);
        check_eq("to_turn_p2", {30'd0, turno_p1, turno_p2}, 32'h1);
        tick();
        check_eq("to_one_cycle", 32'(tiempo_agotado), 32'h0);

        clear_g();
        new_game();
        repeat (7) tick();
        g[7] = 2'b11;
        tick();
        check_eq("to_move_wins", 32'(tiempo_agotado), 32'h0);
        check_eq("to_move_board", 32'(tablero), 32'h3000);
        tick();
        check_eq("to_move_p2", {30'd0, turno_p1, turno_p2}, 32'h1);

        clear_g();
        new_game();
        play(1, 2'b11);
        play(2, 2'b01);
        play(3, 2'b11);
        play(5, 2'b01);
        play(4, 2'b11);
        play(6, 2'b01);
        play(8, 2'b11);
        play(7, 2'b01);
        play(9, 2'b11);
        check_eq("draw_empate", 32'(empate), 32'h1);
        check_eq("draw_no_win", {30'd0, gana_p1, gana_p2}, 32'h0);
        check_eq("draw_board", 32'(tablero), 32'h3D5F7);
        check_eq("draw_linea", 32'(linea_ganadora), 32'h0);

        clear_g();
        new_game();
        play(1, 2'b11);
        play(4, 2'b01);
        play(2, 2'b11);
        play(5, 2'b01);
        play(9, 2'b11);
        play(6, 2'b01);
        check_eq("p2_gana", {29'd0, gana_p1, gana_p2, empate}, 32'h2);
        check_eq("p2_linea", 32'(linea_ganadora), 32'h02);

        clear_g();
        new_game();
        g[1] = 2'b11;
        tick();
        rst_n = 1'b0;
        tick();
        check_eq("rst_mid_eval_board", 32'(tablero), 32'h0);
        check_eq("rst_mid_eval_state", 32'(estado_o), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("rst_release_p1", {30'd0, turno_p1, turno_p2}, 32'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
